// File: rtl/kevin_scan_if.sv
// Host-side handshake bundle for the Kevin-number range scanner.
// The host drives start/abort/range; the controller returns status and results.
interface kevin_scan_if;
    logic       start;
    logic       abort;
    logic [3:0] lo;
    logic [3:0] hi;
    logic       busy;
    logic       done;
    logic [3:0] cur;
    logic       cur_match;
    logic [4:0] match_cnt;
    logic [3:0] first_hit;
    logic       hit_valid;

    modport master (
        output start, abort, lo, hi,
        input  busy, done, cur, cur_match, match_cnt, first_hit, hit_valid
    );

    modport slave (
        input  start, abort, lo, hi,
        output busy, done, cur, cur_match, match_cnt, first_hit, hit_valid
    );
endinterface

// File: rtl/kevin_scan_ctrl.sv
// Range-scan engine around the Kevin-number detector; start-to-done latency is N+1 cycles.
// No backpressure: start is ignored while scanning or done, abort only acts while scanning.
module kevin_scan_ctrl (
    input  logic         clk,
    input  logic         rst,
    kevin_scan_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    logic [3:0] hi_q;
    logic [3:0] cur_q;
    logic [4:0] cnt_q;
    logic [3:0] first_q;
    logic       hv_q;
    logic       busy_q;
    logic       done_q;
    logic       hit;

    function automatic logic is_kevin(input logic [3:0] v);
        case (v)
            4'd1, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10, 4'd12, 4'd14: return 1'b1;
            default:                                          return 1'b0;
        endcase
    endfunction

    // Detector is purely combinational on the registered cursor.
    assign hit = busy_q & is_kevin(cur_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            hi_q    <= 4'd0;
            cur_q   <= 4'd0;
            cnt_q   <= 5'd0;
            first_q <= 4'd0;
            hv_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        hi_q    <= bus.hi;
                        cur_q   <= bus.lo;
                        cnt_q   <= 5'd0;
                        first_q <= 4'd0;
                        hv_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        state   <= SCAN;
                    end
                end
                SCAN: begin
                    if (bus.abort) begin
                        cur_q   <= 4'd0;
                        cnt_q   <= 5'd0;
                        first_q <= 4'd0;
                        hv_q    <= 1'b0;
                        busy_q  <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        if (hit) begin
                            cnt_q <= cnt_q + 5'd1;
                            if (!hv_q) begin
                                first_q <= cur_q;
                                hv_q    <= 1'b1;
                            end
                        end
                        // Equality against the latched end value lets lo>hi wrap naturally.
                        if (cur_q == hi_q) begin
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            state  <= DONE;
                        end else begin
                            cur_q <= cur_q + 4'd1;
                        end
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.cur       = cur_q;
    assign bus.cur_match = hit;
    assign bus.match_cnt = cnt_q;
    assign bus.first_hit = first_q;
    assign bus.hit_valid = hv_q;
endmodule
